mul_issue_ctrl: RTL and testbench
=================================

# mul_issue_ctrl

Issue and writeback controller for the core's pipelined RV32M multiplier (NUM_STAGE-deep). Accepts multiply requests from decode over a valid/ready handshake, launches at most one per cycle, and tracks each destination register through the pipeline in a tag shift register. Results land in a result FIFO that drains to writeback under backpressure. Also supplies a register-busy lookup for decode hazard detection and a sticky consistency-error flag.

## Interface
- NUM_STAGE, 2, multiplier pipeline depth in cycles (>=1); must equal the attached multiplier's setting.
- FIFO_DEPTH, 4, result FIFO entries (>=1); also the issue credit limit.

- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-high.
- req_valid_i  in  1  decode has a multiply request.
- req_ready_o  out  1  controller accepts the request this cycle.
- req_funct3_i  in  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU.
- req_rd_i  in  5  destination register.
- req_in1_i, req_in2_i  in  32  operands (rs1, rs2 values).
- mul_in1_o, mul_in2_o  out  32  multiplier operands.
- mul_opcode_o  out  7  0110011 on issue, else 0000000.
- mul_funct7_o  out  7  0000001 on issue, else 0000000.
- mul_funct3_o  out  3  funct3 on issue, else 000.
- mul_result_i  in  32  multiplier result.
- mul_valid_i  in  1  multiplier result-valid.
- wb_valid_o  out  1  FIFO head valid.
- wb_ready_i  in  1  writeback consumes head.
- wb_rd_o  out  5  head destination register.
- wb_data_o  out  32  head result.
- hz_rs1_i, hz_rs2_i  in  5  decode source registers.
- hz_busy_o  out  1  a source register has a pending result.
- busy_o  out  1  any op in flight or buffered.
- err_o  out  1  sticky tracking/multiplier mismatch.

## Operation
- Credit count = ops in flight + FIFO occupancy, range 0..FIFO_DEPTH. Accept = req_valid_i & req_ready_o, with req_ready_o = (credits < FIFO_DEPTH) | pop this cycle.
- Issue is combinational: on accept, mul_* outputs carry the request; otherwise the opcode/funct7/funct3 outputs are zero and operands hold 0.
- Tag pipe: NUM_STAGE entries of {valid, rd}; stage 0 loads {accept, req_rd_i}; shifts every cycle, no stall.
- Pipe exit: when the last stage is valid, push {rd, mul_result_i} into the FIFO. Credits guarantee no overflow; an overflow attempt sets err_o and the push is dropped.
- err_o also sets when mul_valid_i differs from the tag pipe's last-stage valid. It clears only on reset.
- FIFO pop = wb_valid_o & wb_ready_i. Simultaneous push and pop at full or empty is legal; occupancy stays unchanged. Pointers wrap modulo FIFO_DEPTH.
- hz_busy_o = OR over valid tag-pipe and FIFO entries of (rd != 0) & (rd == hz_rs1_i | rd == hz_rs2_i). rd = 0 never matches. A register leaves the busy set in the cycle its entry pops.
- busy_o = credits != 0.
- rd = 0 requests still execute and write back.

## Timing
- Reset values: req_ready_o 1, wb_valid_o 0, wb_rd_o 0, wb_data_o 0, hz_busy_o 0, busy_o 0, err_o 0, mul_* 0. Tag pipe, FIFO and credits clear.
- Reset asserted mid-operation discards all in-flight and buffered ops. Results arriving afterwards are ignored and do not set err_o.
- Latency: request accepted in cycle t; result on mul_result_i in cycle t+NUM_STAGE; wb_valid_o high in cycle t+NUM_STAGE+1 (FIFO output registered, no bypass).
- Throughput: 1 op/cycle sustained while wb_ready_i is held high.
- hz_busy_o is combinational from hz_rs*_i and registered state. It is high from cycle t+1 through the pop cycle.
- Outputs wb_* are stable while wb_valid_o & !wb_ready_i.

## Test plan
- Single MUL: in1 = 1234, in2 = 5678, rd = 5, NUM_STAGE = 2, wb_ready_i = 1. Required: wb_valid_o high only in cycle t+3, wb_data_o = 7006652, wb_rd_o = 5; busy_o returns low.
- Back-to-back: 5 consecutive MULHU ops, 0xFFFFFFFF*0xFFFFFFFF, rd = 1..5, funct3 = 011. Required: req_ready_o always 1; 5 consecutive wb beats of 0xFFFFFFFE with rd 1..5 in order; err_o stays 0.
- Backpressure: wb_ready_i = 0 and 6 requests offered. Required: exactly 4 accepted, then req_ready_o = 0. After wb_ready_i = 1, 4 in-order pops, then the remaining 2 are accepted. No loss.
- Hazard: issue MUL with rd = 7, then check hz_rs1_i = 7 -> hz_busy_o = 1 until the pop. With hz_rs2_i = 0 and an rd = 0 op in flight -> hz_busy_o = 0.
- Reset mid-flight: 3 ops in flight, pulse rst_i. Required: all outputs at reset values immediately, no wb beats follow, err_o = 0.
- Mismatch: force mul_valid_i = 1 with an empty tag pipe. Required: err_o = 1 the next cycle and it stays 1 until reset.

Source files
------------

// File: rtl/mul_issue_ctrl.sv
// ============================================================================
//  Module   : mul_issue_ctrl
//  Purpose  : Issue/writeback controller for a pipelined RV32M multiplier.
//             Credit-limited valid/ready issue, destination tag pipe that
//             mirrors the multiplier latency, result FIFO towards writeback,
//             decode hazard lookup and sticky consistency-error flag.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_issue_ctrl #(
  parameter int NUM_STAGE  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  // decode request
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_funct3_i,
  input  logic [4:0]  req_rd_i,
  input  logic [31:0] req_in1_i,
  input  logic [31:0] req_in2_i,
  // multiplier
  output logic [31:0] mul_in1_o,
  output logic [31:0] mul_in2_o,
  output logic [6:0]  mul_opcode_o,
  output logic [6:0]  mul_funct7_o,
  output logic [2:0]  mul_funct3_o,
  input  logic [31:0] mul_result_i,
  input  logic        mul_valid_i,
  // writeback
  output logic        wb_valid_o,
  input  logic        wb_ready_i,
  output logic [4:0]  wb_rd_o,
  output logic [31:0] wb_data_o,
  // hazard lookup and status
  input  logic [4:0]  hz_rs1_i,
  input  logic [4:0]  hz_rs2_i,
  output logic        hz_busy_o,
  output logic        busy_o,
  output logic        err_o
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FL_W  = $clog2(NUM_STAGE + 1);

  localparam logic [CNT_W-1:0] C_DEPTH    = CNT_W'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] C_PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [FL_W-1:0]  C_FLUSH    = FL_W'(NUM_STAGE);
  localparam logic [6:0]       C_OPC_OP   = 7'b0110011;
  localparam logic [6:0]       C_F7_MUL   = 7'b0000001;

  // credit and FIFO bookkeeping
  logic [CNT_W-1:0]  r_credits;
  logic [CNT_W-1:0]  r_fifo_cnt;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [FIFO_DEPTH-1:0] r_fifo_vld;
  logic [4:0]        r_fifo_rd   [FIFO_DEPTH];
  logic [31:0]       r_fifo_data [FIFO_DEPTH];

  // destination tags travelling alongside the multiplier pipeline
  logic [NUM_STAGE-1:0] r_tag_vld;
  logic [4:0]           r_tag_rd [NUM_STAGE];

  // cycles after reset during which stale multiplier results are ignored
  logic [FL_W-1:0]   r_flush;
  logic              r_err;

  logic w_head_vld;
  logic w_pop;
  logic w_accept;
  logic w_push;
  logic w_full;
  logic w_overflow;
  logic w_wr_en;
  logic w_hz_busy;

  // --------------------------------------------------------------------------
  // handshake and issue
  // --------------------------------------------------------------------------
  assign w_head_vld  = (r_fifo_cnt != '0);
  assign w_pop       = w_head_vld & wb_ready_i;
  assign req_ready_o = (r_credits < C_DEPTH) | w_pop;
  // Nothing may launch while reset is held, so the multiplier inputs show
  // their idle values for the whole reset window.
  assign w_accept    = req_valid_i & req_ready_o & ~rst_i;

  assign mul_in1_o    = w_accept ? req_in1_i    : 32'd0;
  assign mul_in2_o    = w_accept ? req_in2_i    : 32'd0;
  assign mul_opcode_o = w_accept ? C_OPC_OP     : 7'd0;
  assign mul_funct7_o = w_accept ? C_F7_MUL     : 7'd0;
  assign mul_funct3_o = w_accept ? req_funct3_i : 3'd0;

  // --------------------------------------------------------------------------
  // pipe exit into the FIFO
  // --------------------------------------------------------------------------
  assign w_push     = r_tag_vld[NUM_STAGE-1];
  assign w_full     = (r_fifo_cnt == C_DEPTH);
  assign w_overflow = w_push & w_full & ~w_pop;
  assign w_wr_en    = w_push & ~w_overflow;

  // Credits count ops in flight plus buffered results; a dropped push also
  // returns its credit so the count stays tied to real occupancy.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_credits <= '0;
    end else begin
      r_credits <= r_credits + CNT_W'(w_accept) - CNT_W'(w_pop) - CNT_W'(w_overflow);
    end
  end

  // Tag shift register: advances every cycle in lock-step with the multiplier.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_tag_vld <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        r_tag_rd[i] <= 5'd0;
      end
    end else begin
      r_tag_vld[0] <= w_accept;
      r_tag_rd[0]  <= req_rd_i;
      for (int i = 1; i < NUM_STAGE; i++) begin
        r_tag_vld[i] <= r_tag_vld[i-1];
        r_tag_rd[i]  <= r_tag_rd[i-1];
      end
    end
  end

  // Result FIFO storage and pointers; the pop clear comes first so that a
  // push into the slot being popped (full FIFO) leaves that slot valid.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_fifo_cnt <= '0;
      r_fifo_vld <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_fifo_rd[i]   <= 5'd0;
        r_fifo_data[i] <= 32'd0;
      end
    end else begin
      if (w_pop) begin
        r_fifo_vld[r_rd_ptr] <= 1'b0;
        r_rd_ptr <= (r_rd_ptr == C_PTR_LAST) ? '0 : r_rd_ptr + 1'b1;
      end
      if (w_wr_en) begin
        r_fifo_vld[r_wr_ptr]  <= 1'b1;
        r_fifo_rd[r_wr_ptr]   <= r_tag_rd[NUM_STAGE-1];
        r_fifo_data[r_wr_ptr] <= mul_result_i;
        r_wr_ptr <= (r_wr_ptr == C_PTR_LAST) ? '0 : r_wr_ptr + 1'b1;
      end
      r_fifo_cnt <= r_fifo_cnt + CNT_W'(w_wr_en) - CNT_W'(w_pop);
    end
  end

  // Sticky error; the post-reset window hides results of discarded ops that
  // were already inside the multiplier when reset hit.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_flush <= C_FLUSH;
      r_err   <= 1'b0;
    end else begin
      if (r_flush != '0) begin
        r_flush <= r_flush - 1'b1;
      end
      if (w_overflow || ((mul_valid_i != w_push) && (r_flush == '0))) begin
        r_err <= 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // hazard lookup
  // --------------------------------------------------------------------------
  function automatic logic rd_hit(input logic [4:0] rd,
                                  input logic [4:0] rs1,
                                  input logic [4:0] rs2);
    return (rd != 5'd0) && ((rd == rs1) || (rd == rs2));
  endfunction

  // Any pending destination, in the pipe or buffered, that matches a source.
  always_comb begin
    w_hz_busy = 1'b0;
    for (int i = 0; i < NUM_STAGE; i++) begin
      if (r_tag_vld[i] && rd_hit(r_tag_rd[i], hz_rs1_i, hz_rs2_i)) begin
        w_hz_busy = 1'b1;
      end
    end
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      if (r_fifo_vld[i] && rd_hit(r_fifo_rd[i], hz_rs1_i, hz_rs2_i)) begin
        w_hz_busy = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // outputs
  // --------------------------------------------------------------------------
  assign wb_valid_o = w_head_vld;
  assign wb_rd_o    = w_head_vld ? r_fifo_rd[r_rd_ptr]   : 5'd0;
  assign wb_data_o  = w_head_vld ? r_fifo_data[r_rd_ptr] : 32'd0;
  assign hz_busy_o  = w_hz_busy;
  assign busy_o     = (r_credits != '0);
  assign err_o      = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mul_issue_ctrl.sv
// ============================================================================
//  Module   : tb_mul_issue_ctrl
//  Purpose  : Directed self-checking bench for mul_issue_ctrl with a
//             behavioural NUM_STAGE-deep RV32M multiplier attached.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_issue_ctrl;

  localparam int NS = 2;
  localparam int FD = 4;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_funct3_i;
  logic [4:0]  req_rd_i;
  logic [31:0] req_in1_i;
  logic [31:0] req_in2_i;
  logic [31:0] mul_in1_o;
  logic [31:0] mul_in2_o;
  logic [6:0]  mul_opcode_o;
  logic [6:0]  mul_funct7_o;
  logic [2:0]  mul_funct3_o;
  logic [31:0] mul_result_i;
  logic        mul_valid_i;
  logic        wb_valid_o;
  logic        wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic [4:0]  hz_rs1_i;
  logic [4:0]  hz_rs2_i;
  logic        hz_busy_o;
  logic        busy_o;
  logic        err_o;

  int n_total = 0;
  int n_bad   = 0;

  logic force_v = 1'b0;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.NUM_STAGE(NS), .FIFO_DEPTH(FD)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_funct3_i(req_funct3_i), .req_rd_i(req_rd_i),
    .req_in1_i(req_in1_i), .req_in2_i(req_in2_i),
    .mul_in1_o(mul_in1_o), .mul_in2_o(mul_in2_o),
    .mul_opcode_o(mul_opcode_o), .mul_funct7_o(mul_funct7_o),
    .mul_funct3_o(mul_funct3_o),
    .mul_result_i(mul_result_i), .mul_valid_i(mul_valid_i),
    .wb_valid_o(wb_valid_o), .wb_ready_i(wb_ready_i),
    .wb_rd_o(wb_rd_o), .wb_data_o(wb_data_o),
    .hz_rs1_i(hz_rs1_i), .hz_rs2_i(hz_rs2_i),
    .hz_busy_o(hz_busy_o), .busy_o(busy_o), .err_o(err_o)
  );

  // behavioural multiplier, NS cycles deep, not reset
  function automatic logic [31:0] mul_ref(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, p;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (f)
      3'b001:  p = sa * sb;
      3'b010:  p = sa * ub;
      default: p = ua * ub;
    endcase
    return (f == 3'b000) ? p[31:0] : p[63:32];
  endfunction

  logic [NS-1:0] mp_vld = '0;
  logic [31:0]   mp_res [NS];

  always @(posedge clk) begin
    mp_vld[0] <= (mul_opcode_o == 7'b0110011);
    mp_res[0] <= mul_ref(mul_funct3_o, mul_in1_o, mul_in2_o);
    for (int i = 1; i < NS; i++) begin
      mp_vld[i] <= mp_vld[i-1];
      mp_res[i] <= mp_res[i-1];
    end
  end

  assign mul_valid_i  = mp_vld[NS-1] | force_v;
  assign mul_result_i = mp_res[NS-1];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h @%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic v, input logic [2:0] f, input logic [4:0] rd,
                           input logic [31:0] a, input logic [31:0] b);
    req_valid_i  = v;
    req_funct3_i = f;
    req_rd_i     = rd;
    req_in1_i    = a;
    req_in2_i    = b;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i = 1'b1;
    wb_ready_i = 1'b1;
    hz_rs1_i = 5'd0;
    hz_rs2_i = 5'd0;
    drive_req(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);

    // ---------------- reset state ----------------
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready",  32'(req_ready_o), 32'd1);
    check("rst_wbv",    32'(wb_valid_o), 32'd0);
    check("rst_wbrd",   32'(wb_rd_o), 32'd0);
    check("rst_wbdata", wb_data_o, 32'd0);
    check("rst_hz",     32'(hz_busy_o), 32'd0);
    check("rst_busy",   32'(busy_o), 32'd0);
    check("rst_err",    32'(err_o), 32'd0);
    check("rst_opc",    32'(mul_opcode_o), 32'd0);
    tick();
    rst_i = 1'b0;
    repeat (4) tick();

    // ---------------- single MUL ----------------
    hz_rs1_i = 5'd5;
    tick();
    drive_req(1'b1, 3'd0, 5'd5, 32'd1234, 32'd5678);
    @(negedge clk);
    check("s_ready", 32'(req_ready_o), 32'd1);
    check("s_opc",   32'(mul_opcode_o), 32'h33);
    check("s_f7",    32'(mul_funct7_o), 32'd1);
    check("s_f3",    32'(mul_funct3_o), 32'd0);
    check("s_in1",   mul_in1_o, 32'd1234);
    check("s_in2",   mul_in2_o, 32'd5678);
    check("s_hz0",   32'(hz_busy_o), 32'd0);
    for (int k = 1; k <= 5; k++) begin
      tick();
      drive_req(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("s_wbv",  32'(wb_valid_o), 32'(k == 3));
      check("s_hz",   32'(hz_busy_o), 32'(k <= 3));
      check("s_busy", 32'(busy_o), 32'(k <= 3));
      if (k == 1) check("s_idle_in1", mul_in1_o, 32'd0);
      if (k == 3) begin
        check("s_data", wb_data_o, 32'd7006652);
        check("s_rd",   32'(wb_rd_o), 32'd5);
      end
    end

    // ---------------- back-to-back MULHU ----------------
    for (int k = 0; k < 12; k++) begin
      tick();
      if (k < 5) drive_req(1'b1, 3'b011, 5'(k + 1), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      else       drive_req(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      if (k < 5) check("b_ready", 32'(req_ready_o), 32'd1);
      check("b_wbv", 32'(wb_valid_o), 32'((k >= 3) && (k <= 7)));
      if ((k >= 3) && (k <= 7)) begin
        check("b_data", wb_data_o, 32'hFFFF_FFFE);
        check("b_rd",   32'(wb_rd_o), 32'(k - 2));
      end
    end
    check("b_err", 32'(err_o), 32'd0);

    // ---------------- backpressure ----------------
    wb_ready_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      drive_req(1'b1, 3'd0, 5'(10 + k), 32'(k + 1), 32'd3);
      @(negedge clk);
      check("p_ready", 32'(req_ready_o), 32'(k < 4));
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_req(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("p_hold_v",  32'(wb_valid_o), 32'd1);
      check("p_hold_rd", 32'(wb_rd_o), 32'd10);
      check("p_hold_d",  wb_data_o, 32'd3);
      check("p_full",    32'(req_ready_o), 32'd0);
    end
    for (int p = 0; p < 4; p++) begin
      tick();
      wb_ready_i = 1'b1;
      @(negedge clk);
      check("p_pop_v",  32'(wb_valid_o), 32'd1);
      check("p_pop_rd", 32'(wb_rd_o), 32'(10 + p));
      check("p_pop_d",  wb_data_o, 32'(3 * (p + 1)));
    end
    tick();
    @(negedge clk);
    check("p_empty", 32'(wb_valid_o), 32'd0);
    check("p_idle",  32'(busy_o), 32'd0);
    for (int q = 0; q < 6; q++) begin
      tick();
      if (q < 2) drive_req(1'b1, 3'd0, 5'(14 + q), 32'(5 + q), 32'd3);
      else       drive_req(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      if (q < 2) check("p_rest_ready", 32'(req_ready_o), 32'd1);
      check("p_rest_v", 32'(wb_valid_o), 32'((q == 3) || (q == 4)));
      if ((q == 3) || (q == 4)) begin
        check("p_rest_rd", 32'(wb_rd_o), 32'(11 + q));
        check("p_rest_d",  wb_data_o, 32'(3 * (q + 2)));
      end
    end

    // ---------------- hazard ----------------
    hz_rs1_i = 5'd7;
    hz_rs2_i = 5'd0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 0) drive_req(1'b1, 3'd0, 5'd7, 32'd2, 32'd3);
      else        drive_req(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("h_busy7", 32'(hz_busy_o), 32'((k >= 1) && (k <= 3)));
    end
    hz_rs1_i = 5'd9;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) drive_req(1'b1, 3'd0, 5'd0, 32'd2, 32'd3);
      else        drive_req(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
      @(negedge clk);
      check("h_x0", 32'(hz_busy_o), 32'd0);
      if (k == 1) check("h_x0_busy", 32'(busy_o), 32'd1);
      if (k == 3) begin
        check("h_x0_wbv", 32'(wb_valid_o), 32'd1);
        check("h_x0_rd",  32'(wb_rd_o), 32'd0);
        check("h_x0_d",   wb_data_o, 32'd6);
      end
    end

    // ---------------- reset mid-flight ----------------
    hz_rs1_i = 5'd21;
    for (int k = 0; k < 3; k++) begin
      tick();
      drive_req(1'b1, 3'd0, 5'(20 + k), 32'(k + 2), 32'(k + 3));
      @(negedge clk);
    end
    tick();
    drive_req(1'b0, 3'd0, 5'd0, 32'd0, 32'd0);
    rst_i = 1'b1;
    #1;
    check("r_wbv",   32'(wb_valid_o), 32'd0);
    check("r_wbrd",  32'(wb_rd_o), 32'd0);
    check("r_wbd",   wb_data_o, 32'd0);
    check("r_busy",  32'(busy_o), 32'd0);
    check("r_ready", 32'(req_ready_o), 32'd1);
    check("r_hz",    32'(hz_busy_o), 32'd0);
    check("r_err",   32'(err_o), 32'd0);
    tick();
    rst_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      check("r_after_wbv", 32'(wb_valid_o), 32'd0);
      check("r_after_err", 32'(err_o), 32'd0);
    end

    // ---------------- mismatch ----------------
    tick();
    force_v = 1'b1;
    @(negedge clk);
    check("m_pre", 32'(err_o), 32'd0);
    tick();
    force_v = 1'b0;
    @(negedge clk);
    check("m_set", 32'(err_o), 32'd1);
    repeat (3) tick();
    @(negedge clk);
    check("m_sticky", 32'(err_o), 32'd1);
    tick();
    rst_i = 1'b1;
    #1;
    check("m_clear", 32'(err_o), 32'd0);
    tick();
    rst_i = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
